// File: rtl/opl3_pkg.sv
// Shared types for the host write path: sequencer states and width helpers.
package opl3_pkg;

  typedef enum logic [0:0] {
    SEQ_IDLE = 1'b0,
    SEQ_WAIT = 1'b1
  } seq_state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int bank_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/host_cmd_fifo.sv
// Synchronous first-word-fall-through command FIFO with occupancy output.
module host_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   ic_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   level_reg;
  logic             pop_ok, push_ok;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == (PTR_W+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign level = level_reg;

endmodule

// File: rtl/host_wr_sequencer.sv
// Host write path: edge-detected bus writes queue into a FIFO, drained as paced
// register writes using per-bank latched addresses; plus a status/diagnostic read mux.
module host_wr_sequencer
  import opl3_pkg::*;
#(
  parameter int ADDR_WIDTH      = 2,
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_BANKS       = 2,
  parameter int FIFO_DEPTH      = 16,
  parameter int MIN_WR_INTERVAL = 32
) (
  input  logic                              clk,
  input  logic                              ic_n,
  input  logic                              cs_n,
  input  logic                              rd_n,
  input  logic                              wr_n,
  input  logic [ADDR_WIDTH-1:0]             address,
  input  logic [DATA_WIDTH-1:0]             din,
  output logic [DATA_WIDTH-1:0]             dout,
  input  logic [DATA_WIDTH-1:0]             status,
  output logic                              reg_wr_valid,
  output logic [bank_width(NUM_BANKS)-1:0]  reg_wr_bank,
  output logic [DATA_WIDTH-1:0]             reg_wr_address,
  output logic [DATA_WIDTH-1:0]             reg_wr_data,
  output logic                              busy,
  output logic                              overflow,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);
  localparam int BANK_W  = bank_width(NUM_BANKS);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W   = $clog2(MIN_WR_INTERVAL + 1);
  localparam int CMD_W   = BANK_W + 1 + DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] NUM_BANKS_A = ADDR_WIDTH'(NUM_BANKS);

  typedef struct packed {
    logic [BANK_W-1:0]     bank;
    logic                  is_data;
    logic [DATA_WIDTH-1:0] data;
  } host_cmd_t;

  typedef struct packed {
    logic                  valid;
    logic [BANK_W-1:0]     bank;
    logic [DATA_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data;
  } reg_wr_t;

  logic                  wr, rd, wr_p1_reg, rd_p1_reg;
  logic [ADDR_WIDTH-2:0] bank_idx;
  logic                  bank_ok, push_req, fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CMD_W-1:0]      head_bits;
  logic [LEVEL_W-1:0]    level_w;
  host_cmd_t             push_cmd, head_cmd;
  seq_state_t            state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0] latch_reg [NUM_BANKS];
  logic                  latch_we;
  reg_wr_t               wr_out_reg, wr_out_next;
  logic                  busy_reg, overflow_reg, overflow_next, ovf_set;
  logic [DATA_WIDTH-1:0] dout_reg, diag_word;
  genvar                 gi;

  assign wr       = !cs_n && !wr_n;
  assign rd       = !cs_n && !rd_n;
  assign bank_idx = address[ADDR_WIDTH-1:1];
  // Writes to nonexistent banks vanish without flagging overflow.
  assign bank_ok  = ({1'b0, bank_idx} < NUM_BANKS_A);
  assign push_req = wr && !wr_p1_reg && bank_ok;
  assign fifo_push = push_req && (!fifo_full || fifo_pop);
  assign ovf_set   = push_req && fifo_full && !fifo_pop;
  assign push_cmd  = '{bank: bank_idx[BANK_W-1:0], is_data: address[0], data: din};
  assign head_cmd  = head_bits;

  host_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .ic_n  (ic_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (push_cmd),
    .head  (head_bits),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level_w)
  );

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    wr_out_next       = wr_out_reg;
    wr_out_next.valid = 1'b0;
    fifo_pop          = 1'b0;
    latch_we          = 1'b0;
    unique case (state_reg)
      SEQ_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (!head_cmd.is_data) begin
            latch_we = 1'b1;
          end else begin
            wr_out_next.valid   = 1'b1;
            wr_out_next.bank    = head_cmd.bank;
            wr_out_next.address = latch_reg[head_cmd.bank];
            wr_out_next.data    = head_cmd.data;
            if (MIN_WR_INTERVAL > 1) begin
              state_next = SEQ_WAIT;
              cnt_next   = CNT_W'(MIN_WR_INTERVAL - 1);
            end
          end
        end
      end
      SEQ_WAIT: begin
        // Leaving on the count reaching zero lets the next pop land exactly
        // MIN_WR_INTERVAL cycles after the previous one.
        if (cnt_reg <= CNT_W'(1)) begin
          state_next = SEQ_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: state_next = SEQ_IDLE;
    endcase
  end

  assign overflow_next = ovf_set ? 1'b1 :
                         (rd && !rd_p1_reg && address[0]) ? 1'b0 : overflow_reg;

  assign diag_word[DATA_WIDTH-1] = overflow_reg;
  assign diag_word[DATA_WIDTH-2] = busy_reg;
  for (gi = 0; gi < DATA_WIDTH - 2; gi++) begin : g_diag
    if (gi < LEVEL_W) begin : g_lvl
      assign diag_word[gi] = level_w[gi];
    end else begin : g_pad
      assign diag_word[gi] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      for (int i = 0; i < NUM_BANKS; i++) latch_reg[i] <= '0;
    end else if (latch_we) begin
      latch_reg[head_cmd.bank] <= head_cmd.data;
    end
  end

  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      state_reg    <= SEQ_IDLE;
      cnt_reg      <= '0;
      wr_out_reg   <= '0;
      wr_p1_reg    <= 1'b0;
      rd_p1_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      dout_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      wr_out_reg   <= wr_out_next;
      wr_p1_reg    <= wr;
      rd_p1_reg    <= rd;
      busy_reg     <= (level_w != '0) || (state_reg != SEQ_IDLE);
      overflow_reg <= overflow_next;
      if (rd) dout_reg <= address[0] ? diag_word : status;
    end
  end

  assign dout           = dout_reg;
  assign reg_wr_valid   = wr_out_reg.valid;
  assign reg_wr_bank    = wr_out_reg.bank;
  assign reg_wr_address = wr_out_reg.address;
  assign reg_wr_data    = wr_out_reg.data;
  assign busy           = busy_reg;
  assign overflow       = overflow_reg;
  assign fifo_level     = level_w;

endmodule

// File: tb/tb_host_wr_sequencer.sv
// Directed bench for host_wr_sequencer at default parameters.
module tb_host_wr_sequencer;
  logic       clk = 1'b0;
  logic       ic_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       rd_n = 1'b1;
  logic       wr_n = 1'b1;
  logic [1:0] address = 2'b00;
  logic [7:0] din = 8'h00;
  logic [7:0] status = 8'h00;
  logic [7:0] dout;
  logic       reg_wr_valid;
  logic [0:0] reg_wr_bank;
  logic [7:0] reg_wr_address;
  logic [7:0] reg_wr_data;
  logic       busy;
  logic       overflow;
  logic [4:0] fifo_level;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic       bank;
    logic [7:0] addr;
    logic [7:0] data;
  } wr_rec_t;
  wr_rec_t mon_q[$];

  host_wr_sequencer dut (
    .clk            (clk),
    .ic_n           (ic_n),
    .cs_n           (cs_n),
    .rd_n           (rd_n),
    .wr_n           (wr_n),
    .address        (address),
    .din            (din),
    .dout           (dout),
    .status         (status),
    .reg_wr_valid   (reg_wr_valid),
    .reg_wr_bank    (reg_wr_bank),
    .reg_wr_address (reg_wr_address),
    .reg_wr_data    (reg_wr_data),
    .busy           (busy),
    .overflow       (overflow),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reg_wr_valid === 1'b1) begin
      mon_q.push_back('{cyc, reg_wr_bank[0], reg_wr_address, reg_wr_data});
      $display("reg write: cyc=%0d bank=%0d addr=%h data=%h", cyc, reg_wr_bank, reg_wr_address, reg_wr_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One pulse; stamp is the cycle count right after the edge that sampled it.
  task automatic host_write(input logic [1:0] a, input logic [7:0] d, output int stamp);
    cs_n = 1'b0; wr_n = 1'b0; address = a; din = d;
    @(posedge clk); #1 stamp = cyc;
    @(negedge clk); cs_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    $display("host write: addr=%0d data=%h push_cyc=%0d", a, d, stamp);
  endtask

  task automatic host_read(input logic [1:0] a, output logic [7:0] q);
    cs_n = 1'b0; rd_n = 1'b0; address = a;
    @(posedge clk);
    @(negedge clk); q = dout; cs_n = 1'b1; rd_n = 1'b1;
    @(negedge clk);
    $display("host read: addr=%0d dout=%h", a, q);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int  n;
    bit  ok;
    ok = 1'b0;
    for (n = 0; n < budget; n++) begin
      @(negedge clk);
      if (busy === 1'b0 && fifo_level === 5'd0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: busy=%b level=%0d required busy=0 level=0 within %0d cycles", tag, busy, fifo_level, budget);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({dout, reg_wr_valid, reg_wr_bank, reg_wr_address, reg_wr_data, busy, overflow, fifo_level} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: dout=%h valid=%b bank=%b addr=%h data=%h busy=%b ovf=%b level=%0d required all 0",
               dout, reg_wr_valid, reg_wr_bank, reg_wr_address, reg_wr_data, busy, overflow, fifo_level);
    end
    ic_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_write();
    int s0, s1, base;
    logic [7:0] q;
    wr_rec_t r;
    base = mon_q.size();
    host_write(2'b00, 8'h20, s0);
    host_write(2'b01, 8'h5A, s1);
    repeat (40) @(negedge clk);
    n_checks++;
    if (mon_q.size() !== base + 1) begin
      n_fail++;
      $display("FAIL single_count: got %0d writes required 1", mon_q.size() - base);
    end else begin
      r = mon_q[base];
      n_checks++;
      if (r.cyc !== s1 + 1) begin
        n_fail++;
        $display("FAIL single_latency: valid at cyc %0d required %0d", r.cyc, s1 + 1);
      end
      n_checks++;
      if ({r.bank, r.addr, r.data} !== {1'b0, 8'h20, 8'h5A}) begin
        n_fail++;
        $display("FAIL single_fields: bank=%0d addr=%h data=%h required 0/20/5a", r.bank, r.addr, r.data);
      end
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_drop: busy=%b required 0", busy);
    end
    host_read(2'b01, q);
    n_checks++;
    if (q !== 8'h00) begin
      n_fail++;
      $display("FAIL idle_diag: dout=%h required 00", q);
    end
    status = 8'hA5;
    host_read(2'b00, q);
    n_checks++;
    if (q !== 8'hA5) begin
      n_fail++;
      $display("FAIL status_read: dout=%h required a5", q);
    end
    status = 8'h3C;
    repeat (2) @(negedge clk);
    n_checks++;
    if (dout !== 8'hA5) begin
      n_fail++;
      $display("FAIL dout_hold: dout=%h required a5", dout);
    end
  endtask

  task automatic test_banked_writes();
    int s, sd, base;
    wr_rec_t r0, r1;
    base = mon_q.size();
    host_write(2'b00, 8'h40, s);
    host_write(2'b10, 8'hB0, s);
    host_write(2'b01, 8'h11, sd);
    host_write(2'b11, 8'h22, s);
    wait_idle(200, "banked");
    n_checks++;
    if (mon_q.size() !== base + 2) begin
      n_fail++;
      $display("FAIL banked_count: got %0d writes required 2", mon_q.size() - base);
    end else begin
      r0 = mon_q[base];
      r1 = mon_q[base + 1];
      n_checks++;
      if ({r0.bank, r0.addr, r0.data} !== {1'b0, 8'h40, 8'h11} || r0.cyc !== sd + 1) begin
        n_fail++;
        $display("FAIL banked_first: bank=%0d addr=%h data=%h cyc=%0d required 0/40/11 cyc %0d", r0.bank, r0.addr, r0.data, r0.cyc, sd + 1);
      end
      n_checks++;
      if ({r1.bank, r1.addr, r1.data} !== {1'b1, 8'hB0, 8'h22}) begin
        n_fail++;
        $display("FAIL banked_second: bank=%0d addr=%h data=%h required 1/b0/22", r1.bank, r1.addr, r1.data);
      end
      n_checks++;
      if (r1.cyc - r0.cyc !== 32) begin
        n_fail++;
        $display("FAIL banked_interval: spacing %0d cycles required 32", r1.cyc - r0.cyc);
      end
    end
  endtask

  task automatic test_held_strobe();
    int base;
    wr_rec_t r;
    base = mon_q.size();
    cs_n = 1'b0; wr_n = 1'b0; address = 2'b01; din = 8'h33;
    repeat (10) @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
    $display("host write held 10 cycles: addr=1 data=33");
    wait_idle(200, "held");
    n_checks++;
    if (mon_q.size() !== base + 1) begin
      n_fail++;
      $display("FAIL held_count: got %0d writes required 1", mon_q.size() - base);
    end else begin
      r = mon_q[base];
      n_checks++;
      if ({r.bank, r.addr, r.data} !== {1'b0, 8'h40, 8'h33}) begin
        n_fail++;
        $display("FAIL held_fields: bank=%0d addr=%h data=%h required 0/40/33", r.bank, r.addr, r.data);
      end
    end
  endtask

  // 19 data writes two cycles apart: one pop falls inside the window, so the last is dropped.
  task automatic test_overflow();
    int s;
    logic [7:0] q;
    for (int i = 0; i < 19; i++) begin
      host_write(2'b01, 8'h80 + 8'(i), s);
      if (i == 17) begin
        n_checks++;
        if (fifo_level !== 5'd16 || overflow !== 1'b0) begin
          n_fail++;
          $display("FAIL full_accept: level=%0d ovf=%b required 16/0", fifo_level, overflow);
        end
      end
    end
    n_checks++;
    if (fifo_level !== 5'd16 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL full_drop: level=%0d ovf=%b required 16/1", fifo_level, overflow);
    end
    host_read(2'b01, q);
    n_checks++;
    if (q !== 8'hD0) begin
      n_fail++;
      $display("FAIL ovf_diag_read: dout=%h required d0", q);
    end
    host_read(2'b01, q);
    n_checks++;
    if (q !== 8'h50) begin
      n_fail++;
      $display("FAIL ovf_cleared_read: dout=%h required 50", q);
    end
  endtask

  task automatic test_set_wins();
    int s;
    logic [7:0] q;
    host_write(2'b01, 8'hEE, s);
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ovf_set: ovf=%b required 1", overflow);
    end
    cs_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0; address = 2'b01; din = 8'hEF;
    @(posedge clk);
    @(negedge clk);
    q = dout;
    cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
    $display("host write+read same edge: addr=1 data=ef dout=%h", q);
    n_checks++;
    if (q !== 8'hD0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL set_wins: dout=%h ovf=%b required d0/1", q, overflow);
    end
    @(negedge clk);
    host_read(2'b01, q);
    n_checks++;
    if (q !== 8'hD0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_after_set: dout=%h ovf=%b required d0/0", q, overflow);
    end
  endtask

  task automatic test_reset_mid();
    int s, base;
    wr_rec_t r;
    ic_n = 1'b0;
    repeat (2) @(negedge clk);
    ic_n = 1'b1;
    @(negedge clk);
    host_write(2'b00, 8'h99, s);
    host_write(2'b01, 8'h01, s);
    for (int i = 0; i < 5; i++) host_write(2'b01, 8'hC0 + 8'(i), s);
    n_checks++;
    if (fifo_level !== 5'd5 || busy !== 1'b1 || reg_wr_address !== 8'h99) begin
      n_fail++;
      $display("FAIL pre_reset_state: level=%0d busy=%b addr=%h required 5/1/99", fifo_level, busy, reg_wr_address);
    end
    #2 ic_n = 1'b0;
    #1;
    n_checks++;
    if ({dout, reg_wr_valid, reg_wr_bank, reg_wr_address, reg_wr_data, busy, overflow, fifo_level} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: dout=%h valid=%b bank=%b addr=%h data=%h busy=%b ovf=%b level=%0d required all 0",
               dout, reg_wr_valid, reg_wr_bank, reg_wr_address, reg_wr_data, busy, overflow, fifo_level);
    end
    @(negedge clk);
    ic_n = 1'b1;
    base = mon_q.size();
    repeat (80) @(negedge clk);
    n_checks++;
    if (mon_q.size() !== base) begin
      n_fail++;
      $display("FAIL no_write_after_reset: got %0d writes required 0", mon_q.size() - base);
    end
    host_write(2'b01, 8'h77, s);
    repeat (4) @(negedge clk);
    n_checks++;
    if (mon_q.size() !== base + 1) begin
      n_fail++;
      $display("FAIL post_reset_count: got %0d writes required 1", mon_q.size() - base);
    end else begin
      r = mon_q[base];
      n_checks++;
      if ({r.bank, r.addr, r.data} !== {1'b0, 8'h00, 8'h77}) begin
        n_fail++;
        $display("FAIL latch_cleared: bank=%0d addr=%h data=%h required 0/00/77", r.bank, r.addr, r.data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_banked_writes();
    test_held_strobe();
    test_overflow();
    test_set_wins();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
